return_stack: RTL and testbench

Hardware return-address stack that answers the controller's `push`/`pop` call/return strobes. On a call it stores the return PC; on a return it presents the most recent stored PC as the `pcSel=2` jump target. It sits beside the PC register in the fetch stage and is the only storage for return addresses in the processor.

---
 rtl/return_stack.sv | 136 +++++++++++++
 tb/tb_return_stack.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/return_stack.sv
// Return-address stack for the fetch stage. A call pushes pc+1 and a return pops it.
// The current top entry is readable combinationally, so a return can use it in the same cycle.
module return_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  input  logic             clrErr,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W-1:0] SP_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic             ovf_set;
  logic             unf_set;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_MAX);

  always_comb begin
    sp_d     = sp_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    wr_addr  = sp_q;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;

    if (!start) begin
      unique case ({push, pop})
        2'b10: begin
          sp_d    = sp_q + SP_ONE;
          wr_en   = 1'b1;
          wr_addr = sp_q + SP_ONE;
          // When full the count saturates and the write silently replaces the oldest entry.
          if (is_full) begin
            ovf_set = 1'b1;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        2'b01: begin
          if (is_empty) begin
            unf_set = 1'b1;
          end else begin
            sp_d    = sp_q - SP_ONE;
            count_d = count_q - CNT_ONE;
          end
        end
        2'b11: begin
          // Return followed by call: replace the top in place. On an empty stack
          // there is nothing to return from, so behave as an ordinary push.
          if (is_empty) begin
            sp_d    = sp_q + SP_ONE;
            wr_en   = 1'b1;
            wr_addr = sp_q + SP_ONE;
            count_d = CNT_ONE;
          end else begin
            wr_en   = 1'b1;
            wr_addr = sp_q;
          end
        end
        default: ;
      endcase
    end else begin
      sp_d    = '0;
      count_d = '0;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = pushData;
    end
  end

  // A set in the same cycle as clrErr wins; start clears both flags unconditionally.
  always_comb begin
    overflow_d  = (overflow_q & ~clrErr) | ovf_set;
    underflow_d = (underflow_q & ~clrErr) | unf_set;
    if (start) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      mem_q       <= mem_d;
    end
  end

  assign top       = is_empty ? '0 : mem_q[sp_q];
  assign empty     = is_empty;
  assign full      = is_full;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: LIFO order, wrap on overflow, sticky flags,
// combined push/pop, start clear and asynchronous reset.
module tb_return_stack;

  logic        clk;
  logic        rst;
  logic        start;
  logic        push;
  logic        pop;
  logic [11:0] pushData;
  logic        clrErr;
  logic [11:0] top;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_fail   = 0;

  return_stack #(.WIDTH(12), .DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .push(push), .pop(pop),
    .pushData(pushData), .clrErr(clrErr), .top(top), .empty(empty),
    .full(full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the next rising edge applies them.
  task automatic apply(input logic s, input logic pu, input logic po,
                       input logic [11:0] d, input logic c);
    @(negedge clk);
    start = s; push = pu; pop = po; pushData = d; clrErr = c;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0; push = 1'b0; pop = 1'b0; pushData = '0; clrErr = 1'b0;
    #12;
    n_checks++;
    if (top !== 12'h000) begin n_fail++; $display("FAIL reset_top got %h exp 000", top); end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_checks++;
    if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
    n_checks++;
    if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++;
    if ({overflow, underflow} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags got %b exp 00", {overflow, underflow});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_lifo();
    logic [11:0] exp_top [3];
    exp_top[0] = 12'h030; exp_top[1] = 12'h020; exp_top[2] = 12'h010;
    apply(1'b0, 1'b1, 1'b0, 12'h010, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 12'h020, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 12'h030, 1'b0);
    idle();
    n_checks++;
    if (count !== 4'd3) begin n_fail++; $display("FAIL lifo_count got %0d exp 3", count); end
    n_checks++;
    if (top !== 12'h030) begin n_fail++; $display("FAIL lifo_top got %h exp 030", top); end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
      n_checks++;
      if (top !== exp_top[i]) begin
        n_fail++; $display("FAIL lifo_pop%0d got %h exp %h", i, top, exp_top[i]);
      end
    end
    idle();
    n_checks++;
    if (empty !== 1'b1 || top !== 12'h000) begin
      n_fail++; $display("FAIL lifo_drained got empty=%b top=%h exp empty=1 top=000", empty, top);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) begin
      apply(1'b0, 1'b1, 1'b0, 12'(i), 1'b0);
    end
    idle();
    n_checks++;
    if (count !== 4'd8 || full !== 1'b1) begin
      n_fail++; $display("FAIL ovf_full got count=%0d full=%b exp count=8 full=1", count, full);
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    n_checks++;
    if (top !== 12'h009) begin n_fail++; $display("FAIL ovf_top got %h exp 009", top); end
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
      n_checks++;
      if (top !== 12'(9 - k)) begin
        n_fail++; $display("FAIL ovf_pop%0d got %h exp %h", k, top, 12'(9 - k));
      end
    end
    idle();
    n_checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      n_fail++; $display("FAIL ovf_drained got empty=%b count=%0d exp empty=1 count=0", empty, count);
    end
    apply(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
    idle();
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b exp 0", overflow); end
  endtask

  task automatic test_underflow();
    apply(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    idle();
    n_checks++;
    if (underflow !== 1'b1 || count !== 4'd0) begin
      n_fail++; $display("FAIL unf_set got unf=%b count=%0d exp unf=1 count=0", underflow, count);
    end
    apply(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
    idle();
    n_checks++;
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clr got %b exp 0", underflow); end
    apply(1'b0, 1'b0, 1'b1, 12'h000, 1'b1);
    idle();
    n_checks++;
    if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set_wins got %b exp 1", underflow); end
    apply(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
    idle();
  endtask

  task automatic test_push_pop();
    apply(1'b0, 1'b1, 1'b0, 12'h100, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 12'h200, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 12'h300, 1'b0);
    idle();
    n_checks++;
    if (count !== 4'd2 || top !== 12'h300) begin
      n_fail++; $display("FAIL pp_replace got count=%0d top=%h exp count=2 top=300", count, top);
    end
    apply(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    idle();
    n_checks++;
    if (top !== 12'h100) begin n_fail++; $display("FAIL pp_after_pop got %h exp 100", top); end
    apply(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 12'h055, 1'b0);
    idle();
    n_checks++;
    if (count !== 4'd1 || top !== 12'h055 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_empty got count=%0d top=%h unf=%b exp count=1 top=055 unf=0",
               count, top, underflow);
    end
    apply(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    idle();
  endtask

  task automatic test_start();
    for (int i = 1; i <= 9; i++) begin
      apply(1'b0, 1'b1, 1'b0, 12'h040 + 12'(i), 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    end
    idle();
    n_checks++;
    if (count !== 4'd4 || overflow !== 1'b1 || top !== 12'h045) begin
      n_fail++;
      $display("FAIL start_setup got count=%0d ovf=%b top=%h exp count=4 ovf=1 top=045",
               count, overflow, top);
    end
    apply(1'b1, 1'b1, 1'b0, 12'hABC, 1'b0);
    idle();
    n_checks++;
    if (count !== 4'd0 || top !== 12'h000 || overflow !== 1'b0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL start_clear got count=%0d top=%h ovf=%b empty=%b exp 0 000 0 1",
               count, top, overflow, empty);
    end
    apply(1'b0, 1'b1, 1'b0, 12'h777, 1'b0);
    idle();
    n_checks++;
    if (count !== 4'd1 || top !== 12'h777) begin
      n_fail++; $display("FAIL start_push_after got count=%0d top=%h exp 1 777", count, top);
    end
    apply(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    idle();
  endtask

  task automatic test_async_reset();
    apply(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 12'h0A1, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 12'h0A2, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 12'h0A3, 1'b0);
    idle();
    n_checks++;
    if (count !== 4'd3 || underflow !== 1'b1 || top !== 12'h0A3) begin
      n_fail++;
      $display("FAIL arst_setup got count=%0d unf=%b top=%h exp 3 1 0a3", count, underflow, top);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (top !== 12'h000 || count !== 4'd0 || empty !== 1'b1 ||
        overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate got top=%h count=%0d empty=%b ovf=%b unf=%b exp 000 0 1 0 0",
               top, count, empty, overflow, underflow);
    end
    @(negedge clk);
    rst = 1'b1;
    apply(1'b0, 1'b1, 1'b0, 12'h0B0, 1'b0);
    idle();
    n_checks++;
    if (count !== 4'd1 || top !== 12'h0B0) begin
      n_fail++; $display("FAIL arst_release got count=%0d top=%h exp 1 0b0", count, top);
    end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_push_pop();
    test_start();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
